// File: rtl/sram_hs_ram.sv
// sram_hs_ram: single-port RAM behind a valid/ready request port.
// Optional per-byte even parity storage under SRAM_HS_RAM_PARITY_EN.
module sram_hs_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2048,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                write,
  input  logic                valid,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                resp_valid,
  output logic                error
`ifdef SRAM_HS_RAM_PARITY_EN
  ,
  input  logic                par_inj
`endif
);
  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRESP,
    RWAIT,
    RRESP
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [1:0]        cnt;
  logic [1:0]        cnt_n;
  logic              up;
  logic              accept;
  logic              in_range;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     addr_q;
  logic [IW-1:0]     ridx;
  logic              rng_q;
  logic              rrng;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rword;
  logic              perr;

  assign in_range   = {1'b0, addr} < LIMIT;
  assign idx        = addr[IW-1:0];
  assign ready      = up && (state != RWAIT);
  assign accept     = valid && ready;
  assign resp_valid = (state == WRESP) || (state == RRESP);

  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    unique case (state)
      IDLE, WRESP, RRESP: begin
        nxt = IDLE;
        if (accept) begin
          if (write) begin
            nxt = WRESP;
          end else if (RD_LAT == 1) begin
            nxt = RRESP;
          end else begin
            nxt   = RWAIT;
            cnt_n = 2'(RD_LAT - 1);
          end
        end
      end
      RWAIT: begin
        cnt_n = cnt - 2'd1;
        if (cnt == 2'd1) nxt = RRESP;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      up     <= 1'b0;
      addr_q <= '0;
      rng_q  <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      up    <= 1'b1;
      if (accept) begin
        addr_q <= idx;
        rng_q  <= in_range;
      end
    end
  end

  // Nothing can be accepted while waiting, so the array is stable until RRESP.
  assign ridx  = (state == RWAIT) ? addr_q : idx;
  assign rrng  = (state == RWAIT) ? rng_q : in_range;
  assign rword = mem[ridx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      error <= 1'b0;
    end else begin
      rdata <= '0;
      error <= 1'b0;
      if (nxt == RRESP) begin
        rdata <= rrng ? rword : '0;
        error <= !rrng || perr;
      end else if (nxt == WRESP) begin
        error <= !in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && write && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

`ifdef SRAM_HS_RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] rpar;

  always_ff @(posedge clk) begin
    if (accept && write && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) par[idx][i] <= (^wdata[8*i +: 8]) ^ par_inj;
      end
    end
  end

  assign rpar = par[ridx];

  always_comb begin
    perr = 1'b0;
    for (int i = 0; i < NB; i++) begin
      perr = perr | ((^rword[8*i +: 8]) ^ rpar[i]);
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_sram_hs_ram.sv
// tb_sram_hs_ram: scoreboard bench driving two instances (RD_LAT 1 and 3).
// Parity scenario compiled only with SRAM_HS_RAM_PARITY_EN.
module tb_sram_hs_ram;
  localparam int DEPTH = 2048;

  typedef struct {
    bit          wr;
    bit          err;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] addr [2];
  logic [15:0] wdata [2];
  logic [1:0]  wstrb [2];
  logic        write [2];
  logic        valid [2];
  logic        ready [2];
  logic [15:0] rdata [2];
  logic        resp_valid [2];
  logic        error [2];
  logic        par_inj [2];

  logic [15:0] mdl [2][DEPTH];
  bit   [1:0]  pbad [2][DEPTH];
  exp_t        sb0[$];
  exp_t        sb1[$];
  int          lat [2] = '{1, 3};
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_hs_ram #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RD_LAT(1)
  ) u_lat1 (
    .clk(clk), .rst_n(rst_n), .addr(addr[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .write(write[0]), .valid(valid[0]),
    .ready(ready[0]), .rdata(rdata[0]), .resp_valid(resp_valid[0]),
    .error(error[0])
`ifdef SRAM_HS_RAM_PARITY_EN
    , .par_inj(par_inj[0])
`endif
  );

  sram_hs_ram #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RD_LAT(3)
  ) u_lat3 (
    .clk(clk), .rst_n(rst_n), .addr(addr[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .write(write[1]), .valid(valid[1]),
    .ready(ready[1]), .rdata(rdata[1]), .resp_valid(resp_valid[1]),
    .error(error[1])
`ifdef SRAM_HS_RAM_PARITY_EN
    , .par_inj(par_inj[1])
`endif
  );

  // Response monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (resp_valid[d] === 1'b1) begin
        exp_t e;
        bit   have;
        have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_resp inst%0d cyc=%0d got resp_valid=1 required 0", d, cyc);
        end else begin
          if (d == 0) e = sb0.pop_front();
          else e = sb1.pop_front();
          checks++;
          if (cyc !== e.due) begin
            errors++;
            $display("FAIL resp_latency inst%0d got cyc=%0d required %0d", d, cyc, e.due);
          end
          checks++;
          if (error[d] !== e.err) begin
            errors++;
            $display("FAIL resp_error inst%0d got %b required %b", d, error[d], e.err);
          end
          if (!e.wr) begin
            checks++;
            if (rdata[d] !== e.data) begin
              errors++;
              $display("FAIL rdata inst%0d got %h required %h", d, rdata[d], e.data);
            end
          end
        end
      end else begin
        checks++;
        if (resp_valid[d] !== 1'b0 || error[d] !== 1'b0 || rdata[d] !== 16'h0) begin
          errors++;
          $display("FAIL idle_outputs inst%0d got rv=%b err=%b rdata=%h required 0/0/0",
                   d, resp_valid[d], error[d], rdata[d]);
        end
      end
    end
  end

  task automatic req(input int d, input bit wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] st,
                     input bit inj, output int acc);
    exp_t e;
    bit   inr;
    int   n;
    inr = a < DEPTH;
    addr[d] = a;
    wdata[d] = wd;
    wstrb[d] = st;
    write[d] = wr;
    par_inj[d] = inj;
    valid[d] = 1'b1;
    n = 0;
    while (ready[d] !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout inst%0d addr=%h got ready=%b required 1", d, a, ready[d]);
      valid[d] = 1'b0;
      acc = cyc;
      return;
    end
    acc = cyc + 1;
    e.wr = wr;
    e.due = acc + (wr ? 0 : lat[d] - 1);
    if (wr) begin
      e.err = !inr;
      e.data = '0;
      if (inr) begin
        for (int b = 0; b < 2; b++) begin
          if (st[b]) begin
            mdl[d][a[10:0]][8*b +: 8] = wd[8*b +: 8];
            pbad[d][a[10:0]][b] = inj;
          end
        end
      end
    end else begin
      e.data = inr ? mdl[d][a[10:0]] : 16'h0;
      e.err = !inr || (pbad[d][a[10:0]] != 2'b00);
    end
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    while ((sb0.size() + sb1.size()) != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if ((sb0.size() + sb1.size()) != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", sb0.size() + sb1.size());
      sb0.delete();
      sb1.delete();
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0;
      write[d] = 1'b0;
      addr[d] = '0;
      wdata[d] = '0;
      wstrb[d] = '0;
      par_inj[d] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 ||
          error[d] !== 1'b0 || rdata[d] !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d got rdy=%b rv=%b err=%b rdata=%h required 0",
                 d, ready[d], resp_valid[d], error[d], rdata[d]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL ready_after_release inst%0d got %b required 0", d, ready[d]);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL ready_first_edge inst%0d got %b required 1", d, ready[d]);
      end
    end
  endtask

  task automatic test_fill(input int d);
    int acc;
    for (int a = 0; a < DEPTH; a++) req(d, 1, 16'(a), 16'(a + 1), 2'b11, 0, acc);
    for (int a = 0; a < DEPTH; a++) req(d, 0, 16'(a), 16'h0, 2'b00, 0, acc);
    drain();
  endtask

  task automatic test_range(input int d);
    int acc;
    req(d, 1, 16'd2048, 16'h5555, 2'b11, 0, acc);
    req(d, 1, 16'hF800, 16'h6666, 2'b11, 0, acc);
    req(d, 0, 16'hFFFF, 16'h0, 2'b00, 0, acc);
    req(d, 0, 16'd2048, 16'h0, 2'b00, 0, acc);
    req(d, 0, 16'd0, 16'h0, 2'b00, 0, acc);
    req(d, 0, 16'd2047, 16'h0, 2'b00, 0, acc);
    drain();
  endtask

  task automatic test_strobe(input int d);
    int acc;
    req(d, 1, 16'd5, 16'hAAAA, 2'b11, 0, acc);
    req(d, 1, 16'd5, 16'h1234, 2'b01, 0, acc);
    req(d, 0, 16'd5, 16'h0, 2'b00, 0, acc);
    req(d, 1, 16'd5, 16'hFFFF, 2'b00, 0, acc);
    req(d, 0, 16'd5, 16'h0, 2'b00, 0, acc);
    req(d, 1, 16'd5, 16'h9900, 2'b10, 0, acc);
    req(d, 0, 16'd5, 16'h0, 2'b00, 0, acc);
    drain();
  endtask

  task automatic test_back_to_back();
    int acc;
    int prev;
    for (int k = 0; k < 4; k++) begin
      req(1, 0, 16'(10 + k), 16'h0, 2'b00, 0, acc);
      if (k > 0) begin
        checks++;
        if (acc - prev != 3) begin
          errors++;
          $display("FAIL b2b_read_spacing lat3 got %0d required 3", acc - prev);
        end
      end
      prev = acc;
    end
    for (int k = 0; k < 8; k++) begin
      req(1, 1, 16'(300 + k), 16'(16'hC000 + k), 2'b11, 0, acc);
      if (k > 0) begin
        checks++;
        if (acc - prev != 1) begin
          errors++;
          $display("FAIL b2b_write_spacing got %0d required 1", acc - prev);
        end
      end
      prev = acc;
    end
    for (int k = 0; k < 8; k++) begin
      req(1, 0, 16'(300 + k), 16'h0, 2'b00, 0, acc);
    end
    drain();
    for (int k = 0; k < 4; k++) begin
      req(0, 0, 16'(20 + k), 16'h0, 2'b00, 0, acc);
      if (k > 0) begin
        checks++;
        if (acc - prev != 1) begin
          errors++;
          $display("FAIL b2b_read_spacing lat1 got %0d required 1", acc - prev);
        end
      end
      prev = acc;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int acc;
    req(1, 1, 16'd200, 16'h7777, 2'b11, 0, acc);
    valid[1] = 1'b0;
    rst_n = 1'b0;
    sb1.delete();
    #1;
    req_reset_release();
    req(1, 0, 16'd100, 16'h0, 2'b00, 0, acc);
    valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb1.delete();
    #1;
    checks++;
    if (ready[1] !== 1'b0 || resp_valid[1] !== 1'b0 ||
        error[1] !== 1'b0 || rdata[1] !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs got rdy=%b rv=%b err=%b rdata=%h required 0",
               ready[1], resp_valid[1], error[1], rdata[1]);
    end
    req_reset_release();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
    end
    req(1, 0, 16'd100, 16'h0, 2'b00, 0, acc);
    req(1, 0, 16'd200, 16'h0, 2'b00, 0, acc);
    drain();
  endtask

  task automatic req_reset_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_mid_reset got %b required 1", ready[1]);
    end
  endtask

`ifdef SRAM_HS_RAM_PARITY_EN
  task automatic test_parity(input int d);
    int acc;
    req(d, 1, 16'd7, 16'h3C5A, 2'b11, 1, acc);
    req(d, 0, 16'd7, 16'h0, 2'b00, 0, acc);
    req(d, 1, 16'd7, 16'h3C5A, 2'b11, 0, acc);
    req(d, 0, 16'd7, 16'h0, 2'b00, 0, acc);
    req(d, 1, 16'd7, 16'h00F1, 2'b01, 1, acc);
    req(d, 1, 16'd7, 16'h8100, 2'b10, 0, acc);
    req(d, 0, 16'd7, 16'h0, 2'b00, 0, acc);
    drain();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill(0);
    test_fill(1);
    test_range(0);
    test_range(1);
    test_strobe(0);
    test_strobe(1);
    test_back_to_back();
    test_reset_mid();
`ifdef SRAM_HS_RAM_PARITY_EN
    test_parity(0);
    test_parity(1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
